// File: rtl/sprite_layer.sv
// rtl/sprite_layer.sv - animated, scalable, flippable sprite overlay composited over a background pixel stream
// Three-stage pipeline: address generation, ROM access, palette/background mux.
module sprite_layer #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int FRAME_DIV  = 8,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);

  localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int LXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int LYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [10:0]    W_LIM    = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0]    H_LIM    = 11'(SPR_H << SCALE_LOG2);
  localparam logic [7:0]     DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [FW-1:0]  FR_LAST  = FW'(FRAMES - 1);
  localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

  // Shadow position/flip and animation state, touched only at frame boundaries
  logic [9:0]        r_pos_x_s;
  logic [9:0]        r_pos_y_s;
  logic              r_flip_s;
  logic [7:0]        r_div;
  logic [FW-1:0]     r_anim_frame;
  logic [FW-1:0]     w_frame_next;

  // Pipeline registers
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit1;
  logic              r_blank1;
  logic [11:0]       r_bg1;
  logic              r_hit2;
  logic              r_blank2;
  logic [11:0]       r_bg2;
  logic [3:0]        r_red;
  logic [3:0]        r_green;
  logic [3:0]        r_blue;
  logic              r_sprite_hit;

  // Stage-1 combinational address generation
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_hit;
  logic [LXW-1:0]    w_lx_raw;
  logic [LXW-1:0]    w_lx;
  logic [LYW-1:0]    w_ly;
  logic [ADDR_W-1:0] w_addr;

  // Stage-3 combinational compositing
  logic [11:0]       w_rgb;
  logic              w_shit;

  assign w_frame_next = (r_anim_frame == FR_LAST) ? '0 : r_anim_frame + 1'b1;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_pos_x_s    <= '0;
      r_pos_y_s    <= '0;
      r_flip_s     <= 1'b0;
      r_div        <= '0;
      r_anim_frame <= '0;
    end else if (frame_start) begin
      r_pos_x_s <= pos_x;
      r_pos_y_s <= pos_y;
      r_flip_s  <= flip_h;
      if (anim_restart) begin
        r_div        <= '0;
        r_anim_frame <= '0;
      end else if (anim_en) begin
        if (r_div == DIV_LAST) begin
          r_div        <= '0;
          r_anim_frame <= w_frame_next;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

  // 11-bit subtraction keeps the borrow out of the range test; the >= guards reject left/top wrap
  assign w_dx     = {1'b0, DrawX} - {1'b0, r_pos_x_s};
  assign w_dy     = {1'b0, DrawY} - {1'b0, r_pos_y_s};
  assign w_hit    = (DrawX >= r_pos_x_s) && (w_dx < W_LIM) &&
                    (DrawY >= r_pos_y_s) && (w_dy < H_LIM);
  assign w_lx_raw = LXW'(w_dx >> SCALE_LOG2);
  assign w_ly     = LYW'(w_dy >> SCALE_LOG2);
  assign w_lx     = r_flip_s ? (LXW'(SPR_W - 1) - w_lx_raw) : w_lx_raw;
  assign w_addr   = ADDR_W'(r_anim_frame) * ADDR_W'(SPR_W * SPR_H) +
                    ADDR_W'(w_ly) * ADDR_W'(SPR_W) + ADDR_W'(w_lx);

  always_comb begin
    w_rgb  = 12'h000;
    w_shit = 1'b0;
    if (r_blank2) begin
      if (r_hit2 && (rom_q != TRANSP)) begin
        w_rgb  = {pal_red, pal_green, pal_blue};
        w_shit = 1'b1;
      end else begin
        w_rgb = r_bg2;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_rom_addr   <= '0;
      r_hit1       <= 1'b0;
      r_blank1     <= 1'b0;
      r_bg1        <= '0;
      r_hit2       <= 1'b0;
      r_blank2     <= 1'b0;
      r_bg2        <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_sprite_hit <= 1'b0;
    end else begin
      r_rom_addr   <= w_hit ? w_addr : '0;
      r_hit1       <= w_hit;
      r_blank1     <= blank;
      r_bg1        <= {bg_red, bg_green, bg_blue};
      r_hit2       <= r_hit1;
      r_blank2     <= r_blank1;
      r_bg2        <= r_bg1;
      r_red        <= w_rgb[11:8];
      r_green      <= w_rgb[7:4];
      r_blue       <= w_rgb[3:0];
      r_sprite_hit <= w_shit;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign pal_idx    = rom_q;
  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign sprite_hit = r_sprite_hit;

endmodule

// File: tb/tb_sprite_layer.sv
// tb/tb_sprite_layer.sv - randomized and directed bench for sprite_layer against a pixel-level reference model
module tb_sprite_layer;
  localparam int SW = 64, SH = 64, FR = 4, SC = 1, FD = 2, TI = 0, AW = 14;
  localparam int NMAX = 8192;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [9:0]    DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic          blank = 1'b0, frame_start = 1'b0, flip_h = 1'b0;
  logic          anim_en = 1'b0, anim_restart = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_q = '0;
  logic [3:0]    pal_idx, pal_red, pal_green, pal_blue;
  logic [3:0]    bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [3:0]    red, green, blue;
  logic          sprite_hit;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_px = 0, m_py = 0, m_flip = 0, m_frame = 0, m_div = 0;
  int exp_addr [NMAX];
  int exp_rgb  [NMAX];
  bit exp_sh   [NMAX];
  bit av [NMAX];
  bit ov [NMAX];
  bit fz [NMAX];
  int seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  always #5 clk = ~clk;

  sprite_layer #(.SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .SCALE_LOG2(SC),
                 .FRAME_DIV(FD), .IDX_W(4), .TRANSP_IDX(TI)) dut (
    .vga_clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .anim_en(anim_en), .anim_restart(anim_restart), .rom_addr(rom_addr),
    .rom_q(rom_q), .pal_idx(pal_idx), .pal_red(pal_red), .pal_green(pal_green),
    .pal_blue(pal_blue), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit));

  function automatic logic [3:0] rom_fn(input int a);
    return 4'(a * 7 + (a / 64) * 3 + 9);
  endfunction

  function automatic int pal_rgb(input logic [3:0] q);
    logic [3:0] g, b;
    g = q ^ 4'hA;
    b = q + 4'd3;
    return {20'd0, q, g, b};
  endfunction

  // External synchronous texture ROM and combinational palette
  always @(posedge clk) rom_q <= rom_fn(int'(rom_addr));
  assign pal_red   = pal_idx;
  assign pal_green = pal_idx ^ 4'hA;
  assign pal_blue  = pal_idx + 4'd3;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model one pixel from the current inputs, then advance one clock
  task automatic tick();
    int k, x, y, ddx, ddy, lx, ly, a;
    bit h;
    logic [3:0] q;
    k   = cyc;
    x   = int'(DrawX);
    y   = int'(DrawY);
    ddx = x - m_px;
    ddy = y - m_py;
    h   = (ddx >= 0) && (ddx < (SW << SC)) && (ddy >= 0) && (ddy < (SH << SC));
    a   = 0;
    if (h) begin
      lx = ddx / (1 << SC);
      ly = ddy / (1 << SC);
      if (m_flip != 0) lx = SW - 1 - lx;
      a = m_frame * SW * SH + ly * SW + lx;
    end
    exp_addr[k+1] = a;
    av[k+1] = 1'b1;
    q = rom_fn(a);
    if (!blank) begin
      exp_rgb[k+3] = 0; exp_sh[k+3] = 1'b0;
    end else if (h && q != 4'(TI)) begin
      exp_rgb[k+3] = pal_rgb(q); exp_sh[k+3] = 1'b1;
    end else begin
      exp_rgb[k+3] = {20'd0, bg_red, bg_green, bg_blue}; exp_sh[k+3] = 1'b0;
    end
    ov[k+3] = 1'b1;
    if (Reset) begin
      exp_addr[k+1] = 0;
      fz[k+1] = 1'b1; fz[k+2] = 1'b1; fz[k+3] = 1'b1;
      m_px = 0; m_py = 0; m_flip = 0; m_frame = 0; m_div = 0;
    end else if (frame_start) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_flip = int'(flip_h);
      if (anim_restart) begin
        m_div = 0; m_frame = 0;
      end else if (anim_en) begin
        m_div = m_div + 1;
        if (m_div == FD) begin
          m_div = 0; m_frame = (m_frame + 1) % FR;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); blank = 1'b1;
    tick();
    blank = 1'b0;
  endtask

  task automatic pulse();
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Per-cycle compare against the model
  initial begin
    int n;
    forever begin
      @(negedge clk);
      n = cyc;
      if (n < NMAX) begin
        if (av[n]) chk("rom_addr", int'(rom_addr), exp_addr[n]);
        if (fz[n]) begin
          chk("rgb_reset", int'({red, green, blue}), 0);
          chk("hit_reset", int'(sprite_hit), 0);
        end else if (ov[n]) begin
          chk("rgb", int'({red, green, blue}), exp_rgb[n]);
          chk("sprite_hit", int'(sprite_hit), int'(exp_sh[n]));
        end
      end
    end
  end

  initial begin
    int rx, ry;
    #1;
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    chk("reset_addr", int'(rom_addr), 0);
    chk("reset_hit", int'(sprite_hit), 0);
    bg_red = 4'h5; bg_green = 4'hA; bg_blue = 4'h3;

    // Basic draw at origin of sprite
    pos_x = 10'd100; pos_y = 10'd50;
    pulse();
    pix(100, 50);
    chk("basic_addr", int'(rom_addr), 0);
    tick(); tick();
    chk("basic_red", int'(red), 9);
    chk("basic_green", int'(green), 3);
    chk("basic_blue", int'(blue), 12);
    chk("basic_hit", int'(sprite_hit), 1);

    // Texel 1 is transparent: background shows through
    pix(102, 50);
    chk("transp_addr", int'(rom_addr), 1);
    tick(); tick();
    chk("transp_rgb", int'({red, green, blue}), 12'h5A3);
    chk("transp_hit", int'(sprite_hit), 0);

    // Mid-frame move must not take effect before frame_start
    pos_x = 10'd200;
    pix(110, 50);
    chk("tear_before", int'(rom_addr), 5);
    pulse();
    pix(110, 50);
    chk("tear_after", int'(rom_addr), 0);

    // Blank inside sprite
    pos_x = 10'd100;
    pulse();
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b0;
    tick(); tick(); tick();
    chk("blank_rgb", int'({red, green, blue}), 0);
    chk("blank_hit", int'(sprite_hit), 0);

    // Flip with 2x scale
    pos_x = 10'd0; pos_y = 10'd0; flip_h = 1'b1;
    pulse();
    pix(3, 5);
    chk("flip_addr", int'(rom_addr), 190);

    // Right-edge clipping, no wrap to column 0
    pos_x = 10'd600; pos_y = 10'd50; flip_h = 1'b0;
    pulse();
    pix(639, 50);
    chk("clip_in_addr", int'(rom_addr), 19);
    pix(0, 50);
    chk("clip_wrap_addr", int'(rom_addr), 0);
    tick(); tick();
    chk("clip_wrap_hit", int'(sprite_hit), 0);

    // Animation sequence
    pos_x = 10'd100; pos_y = 10'd50;
    pulse();
    anim_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      pix(100, 50);
      chk("anim_frame", int'(rom_addr), seq[p] * SW * SH);
      pulse();
    end
    pix(100, 50);
    chk("anim_wrap", int'(rom_addr), 0);
    repeat (4) pulse();
    pix(100, 50);
    chk("anim_pre_restart", int'(rom_addr), 2 * SW * SH);
    anim_restart = 1'b1;
    pulse();
    anim_restart = 1'b0;
    pix(100, 50);
    chk("anim_restart", int'(rom_addr), 0);
    repeat (3) pulse();
    anim_restart = 1'b1;
    tick();
    anim_restart = 1'b0;
    pix(100, 50);
    chk("restart_ignored", int'(rom_addr), SW * SH);

    // Reset during active video
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midreset_rgb", int'({red, green, blue}), 0);
    chk("midreset_hit", int'(sprite_hit), 0);
    pix(2, 0);
    chk("midreset_frame", int'(rom_addr), 1);
    anim_en = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pos_x = 10'($urandom_range(0, 639));
        pos_y = 10'($urandom_range(0, 479));
        flip_h = 1'($urandom_range(0, 1));
      end
      rx = int'(pos_x) + int'($urandom_range(0, 140)) - 4;
      ry = int'(pos_y) + int'($urandom_range(0, 140)) - 4;
      DrawX = 10'(rx);
      DrawY = 10'(ry);
      blank = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 29) == 0);
      anim_en = ($urandom_range(0, 3) != 0);
      anim_restart = ($urandom_range(0, 5) == 0);
      Reset = ($urandom_range(0, 299) == 0);
      bg_red = 4'($urandom); bg_green = 4'($urandom); bg_blue = 4'($urandom);
      tick();
    end
    Reset = 1'b0; frame_start = 1'b0; blank = 1'b0; anim_restart = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
